// File: rtl/key_press_encoder.sv
// key_press_encoder: debounces four active-low keys and emits one acknowledged press event per physical press
module key_press_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] key_n,
  input  logic       press_ack,
  output logic [3:0] button_signal,
  output logic       press_valid,
  output logic       multi_press,
  output logic [7:0] press_count
);
  typedef enum logic [1:0] {ARMED, PENDING, WAIT_RELEASE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state, state_n;
  logic [3:0] s1, s2, deb, deb_prev, stale, new_press, btn_n;
  logic [1:0] warm;
  logic [CNT_W-1:0] cnt [4];
  logic valid_n, multi_n, fire;
  logic [7:0] count_n;
  // Keys seen held once the synchronizer has filled after reset are stale until released,
  // so a key held through reset never produces an event on its post-reset debounce edge.
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      s1 <= '0;
      s2 <= '0;
      deb_prev <= '0;
      warm <= '0;
      stale <= '1;
    end else begin
      s1 <= ~key_n;
      s2 <= s1;
      deb_prev <= deb;
      warm <= {warm[0], 1'b1};
      stale <= warm[1] ? stale & s2 : stale;
    end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      deb <= '0;
      cnt <= '{default: '0};
    end else begin
      for (int i = 0; i < 4; i++)
        if (s2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == LAST) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + CNT_W'(1);
    end
  assign new_press = deb & ~deb_prev & ~stale;
  assign fire = |new_press && !(|(deb & ~new_press));
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= ARMED;
      button_signal <= '0;
      press_valid <= 1'b0;
      multi_press <= 1'b0;
      press_count <= '0;
    end else begin
      state <= state_n;
      button_signal <= btn_n;
      press_valid <= valid_n;
      multi_press <= multi_n;
      press_count <= count_n;
    end
  always_comb begin
    state_n = state;
    btn_n = button_signal;
    valid_n = press_valid;
    multi_n = multi_press;
    count_n = press_count;
    case (state)
      ARMED: if (fire) begin
        btn_n = deb;
        valid_n = 1'b1;
        multi_n = |(deb & (deb - 4'd1));
        state_n = PENDING;
      end
      PENDING: if (press_ack) begin
        valid_n = 1'b0;
        multi_n = 1'b0;
        count_n = press_count + 8'd1;
        state_n = WAIT_RELEASE;
      end
      WAIT_RELEASE: if (deb == 4'd0) begin
        btn_n = '0;
        state_n = ARMED;
      end
      default: state_n = ARMED;
    endcase
  end
endmodule

// File: tb/tb_key_press_encoder.sv
// tb_key_press_encoder: directed vectors with hand-computed expectations, DEBOUNCE_CYCLES=4
module tb_key_press_encoder;
  logic clock = 1'b0;
  logic resetn;
  logic [3:0] key_n;
  logic press_ack;
  logic [3:0] button_signal;
  logic press_valid, multi_press;
  logic [7:0] press_count;
  int checks = 0;
  int failures = 0;
  key_press_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clock(clock),
    .resetn(resetn),
    .key_n(key_n),
    .press_ack(press_ack),
    .button_signal(button_signal),
    .press_valid(press_valid),
    .multi_press(multi_press),
    .press_count(press_count)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic ack();
    press_ack = 1'b1;
    step(1);
    press_ack = 1'b0;
  endtask
  initial begin
    resetn = 1'b0;
    key_n = 4'hF;
    press_ack = 1'b0;
    step(2);
    check("rst_valid", 32'(press_valid), 0);
    check("rst_btn", 32'(button_signal), 0);
    check("rst_multi", 32'(multi_press), 0);
    check("rst_count", 32'(press_count), 0);
    resetn = 1'b1;
    step(4);
    // clean press, acked while held, then released
    key_n = 4'b1011;
    step(6);
    check("clean_early", 32'(press_valid), 0);
    step(1);
    check("clean_valid", 32'(press_valid), 1);
    check("clean_btn", 32'(button_signal), 32'h4);
    check("clean_multi", 32'(multi_press), 0);
    ack();
    check("clean_ack_valid", 32'(press_valid), 0);
    check("clean_count", 32'(press_count), 1);
    check("hold_btn", 32'(button_signal), 32'h4);
    key_n = 4'hF;
    step(6);
    check("rel_btn_held", 32'(button_signal), 32'h4);
    step(1);
    check("rel_btn_clear", 32'(button_signal), 0);
    // bounce on key 0, then stable low
    for (int i = 0; i < 5; i++) begin
      key_n = 4'b1110;
      step(2);
      key_n = 4'hF;
      step(2);
    end
    check("bounce_none", 32'(press_valid), 0);
    key_n = 4'b1110;
    step(6);
    check("bounce_early", 32'(press_valid), 0);
    step(1);
    check("bounce_valid", 32'(press_valid), 1);
    check("bounce_btn", 32'(button_signal), 32'h1);
    ack();
    check("bounce_count", 32'(press_count), 2);
    key_n = 4'hF;
    step(8);
    ack();
    check("ack_ignored", 32'(press_count), 2);
    // 3-cycle glitch on key 1
    key_n = 4'b1101;
    step(3);
    key_n = 4'hF;
    step(12);
    check("glitch_valid", 32'(press_valid), 0);
    check("glitch_btn", 32'(button_signal), 0);
    // simultaneous press, extra key during PENDING
    key_n = 4'b0110;
    step(7);
    check("simul_valid", 32'(press_valid), 1);
    check("simul_btn", 32'(button_signal), 32'h9);
    check("simul_multi", 32'(multi_press), 1);
    key_n = 4'b0100;
    step(10);
    check("extra_btn", 32'(button_signal), 32'h9);
    check("extra_valid", 32'(press_valid), 1);
    ack();
    check("simul_ack_valid", 32'(press_valid), 0);
    check("simul_ack_multi", 32'(multi_press), 0);
    check("simul_count", 32'(press_count), 3);
    key_n = 4'hF;
    step(6);
    check("simul_btn_held", 32'(button_signal), 32'h9);
    step(1);
    check("simul_btn_clear", 32'(button_signal), 0);
    // async reset while PENDING, key held through reset
    key_n = 4'b0111;
    step(7);
    check("pre_rst_valid", 32'(press_valid), 1);
    resetn = 1'b0;
    #1;
    check("async_valid", 32'(press_valid), 0);
    check("async_btn", 32'(button_signal), 0);
    check("async_count", 32'(press_count), 0);
    step(2);
    resetn = 1'b1;
    step(12);
    check("held_no_event", 32'(press_valid), 0);
    key_n = 4'hF;
    step(10);
    check("released_no_event", 32'(press_valid), 0);
    key_n = 4'b0111;
    step(7);
    check("repress_valid", 32'(press_valid), 1);
    check("repress_btn", 32'(button_signal), 32'h8);
    ack();
    check("repress_count", 32'(press_count), 1);
    key_n = 4'hF;
    step(8);
    // press_count wrap
    for (int i = 0; i < 255; i++) begin
      key_n = 4'b1110;
      step(7);
      ack();
      key_n = 4'hF;
      step(8);
      if (i == 253) check("count_255", 32'(press_count), 255);
    end
    check("count_wrap", 32'(press_count), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
